// File: rtl/fifo_pkg.sv
// Shared mode type and sizing helpers for the flexible synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int fifo_depth(input int depth_log);
        return 1 << depth_log;
    endfunction

    function automatic int fifo_ptr_w(input int depth_log);
        return depth_log + 1;
    endfunction

endpackage

// File: rtl/fifo_flex_control.sv
// Pointer, occupancy and flag control for fifo_sync_flex, including the
// RAM-stage / output-register pipeline used in first-word-fall-through mode.
module fifo_flex_control #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 2**DEPTH_LOG - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_req,
    input  logic                 read_req,
    output logic                 full,
    output logic                 almost_full,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [DEPTH_LOG:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 read_valid,
    output logic [WIDTH-1:0]     read_data,
    output logic                 ram_write_en,
    output logic [DEPTH_LOG-1:0] ram_write_addr,
    output logic                 ram_read_en,
    output logic [DEPTH_LOG-1:0] ram_read_addr,
    input  logic [WIDTH-1:0]     ram_read_data
);

    import fifo_pkg::*;

    localparam int PTR_W = fifo_ptr_w(DEPTH_LOG);
    localparam int DEPTH = fifo_depth(DEPTH_LOG);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);

    logic [PTR_W-1:0] wptr, rptr, cnt_q;
    logic [PTR_W-1:0] wptr_n, rptr_n, count_n;
    logic             full_q, afull_q, empty_q, aempty_q, ovf_q, unf_q;
    logic             full_n, empty_n;
    logic             stage_valid, stage_valid_n;
    logic             out_valid, out_valid_n;
    logic [WIDTH-1:0] out_data;
    logic             wr_acc, rd_acc, storage_empty, storage_pop, out_load;

    // stage_valid: the RAM read register holds a word not yet moved to the
    // output register. In standard mode it simply marks a read in flight.
    always_comb begin
        wr_acc        = write_req && !full_q;
        rd_acc        = read_req && !empty_q;
        storage_empty = (wptr == rptr);
        if (MODE == FIFO_FWFT) begin
            out_load      = stage_valid && (!out_valid || rd_acc);
            storage_pop   = !storage_empty && (!stage_valid || out_load);
            stage_valid_n = storage_pop || (stage_valid && !out_load);
            out_valid_n   = out_load || (out_valid && !rd_acc);
        end else begin
            out_load      = stage_valid;
            storage_pop   = rd_acc;
            stage_valid_n = rd_acc;
            out_valid_n   = stage_valid;
        end
        wptr_n  = wr_acc ? wptr + 1'b1 : wptr;
        rptr_n  = storage_pop ? rptr + 1'b1 : rptr;
        count_n = cnt_q;
        if (wr_acc && !rd_acc)
            count_n = cnt_q + 1'b1;
        else if (rd_acc && !wr_acc)
            count_n = cnt_q - 1'b1;
        // FWFT capacity spans storage plus the prefetch pipeline, so use the count.
        if (MODE == FIFO_FWFT) begin
            full_n  = (count_n == DEPTH_C);
            empty_n = !out_valid_n;
        end else begin
            full_n  = (wptr_n[DEPTH_LOG-1:0] == rptr_n[DEPTH_LOG-1:0]) &&
                      (wptr_n[DEPTH_LOG] != rptr_n[DEPTH_LOG]);
            empty_n = (wptr_n == rptr_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            stage_valid <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            wptr        <= wptr_n;
            rptr        <= rptr_n;
            cnt_q       <= count_n;
            full_q      <= full_n;
            afull_q     <= (count_n >= AFULL_C);
            empty_q     <= empty_n;
            aempty_q    <= (count_n <= AEMPTY_C);
            ovf_q       <= write_req && full_q;
            unf_q       <= read_req && empty_q;
            stage_valid <= stage_valid_n;
            out_valid   <= out_valid_n;
            if (out_load)
                out_data <= ram_read_data;
        end
    end

    assign full           = full_q;
    assign almost_full    = afull_q;
    assign empty          = empty_q;
    assign almost_empty   = aempty_q;
    assign count          = cnt_q;
    assign overflow       = ovf_q;
    assign underflow      = unf_q;
    assign read_valid     = out_valid;
    assign read_data      = out_data;
    assign ram_write_en   = wr_acc;
    assign ram_write_addr = wptr[DEPTH_LOG-1:0];
    assign ram_read_en    = storage_pop;
    assign ram_read_addr  = rptr[DEPTH_LOG-1:0];

endmodule

// File: rtl/pkg_dual_ram.sv
// Simple dual-port storage: one write port, one registered read port (1-cycle latency).
module pkg_dual_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              ram_write_en,
    input  logic [ADDR_W-1:0] ram_write_addr,
    input  logic [WIDTH-1:0]  ram_write_data,
    input  logic              ram_read_en,
    input  logic [ADDR_W-1:0] ram_read_addr,
    output logic [WIDTH-1:0]  ram_read_data
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (ram_write_en)
            mem[ram_write_addr] <= ram_write_data;
        if (ram_read_en)
            ram_read_data <= mem[ram_read_addr];
    end

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with count, almost flags, error pulses and optional FWFT reads.
module fifo_sync_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 2**DEPTH_LOG - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_write_req,
    input  logic [WIDTH-1:0]   fifo_write_data,
    output logic               fifo_full,
    output logic               fifo_almost_full,
    input  logic               fifo_read_req,
    output logic [WIDTH-1:0]   fifo_read_data,
    output logic               fifo_read_valid,
    output logic               fifo_empty,
    output logic               fifo_almost_empty,
    output logic [DEPTH_LOG:0] fifo_count,
    output logic               fifo_overflow,
    output logic               fifo_underflow
);

    import fifo_pkg::*;

    logic                 ram_write_en, ram_read_en;
    logic [DEPTH_LOG-1:0] ram_write_addr, ram_read_addr;
    logic [WIDTH-1:0]     ram_read_data;

    fifo_flex_control #(
        .WIDTH     (WIDTH),
        .DEPTH_LOG (DEPTH_LOG),
        .FWFT      (FWFT),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_control (
        .clk            (clk),
        .rst            (rst),
        .write_req      (fifo_write_req),
        .read_req       (fifo_read_req),
        .full           (fifo_full),
        .almost_full    (fifo_almost_full),
        .empty          (fifo_empty),
        .almost_empty   (fifo_almost_empty),
        .count          (fifo_count),
        .overflow       (fifo_overflow),
        .underflow      (fifo_underflow),
        .read_valid     (fifo_read_valid),
        .read_data      (fifo_read_data),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_read_en    (ram_read_en),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data)
    );

    pkg_dual_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG)
    ) u_ram (
        .clk            (clk),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (fifo_write_data),
        .ram_read_en    (ram_read_en),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data)
    );

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Drives a standard-mode and an FWFT-mode FIFO with the same stimulus and
// compares both against queue-based reference models every cycle.
module tb_fifo_sync_flex;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wreq = 1'b0;
    logic       rreq = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic       s_full, s_afull, s_empty, s_aempty, s_rv, s_ovf, s_unf;
    logic [7:0] s_rdata;
    logic [3:0] s_cnt;
    logic       f_full, f_afull, f_empty, f_aempty, f_rv, f_ovf, f_unf;
    logic [7:0] f_rdata;
    logic [3:0] f_cnt;

    always #5 clk = ~clk;

    fifo_sync_flex #(.WIDTH(8), .DEPTH_LOG(3), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) dut_std (
        .clk(clk), .rst(rst),
        .fifo_write_req(wreq), .fifo_write_data(wdata),
        .fifo_full(s_full), .fifo_almost_full(s_afull),
        .fifo_read_req(rreq), .fifo_read_data(s_rdata), .fifo_read_valid(s_rv),
        .fifo_empty(s_empty), .fifo_almost_empty(s_aempty), .fifo_count(s_cnt),
        .fifo_overflow(s_ovf), .fifo_underflow(s_unf)
    );

    fifo_sync_flex #(.WIDTH(8), .DEPTH_LOG(3), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2)) dut_fwft (
        .clk(clk), .rst(rst),
        .fifo_write_req(wreq), .fifo_write_data(wdata),
        .fifo_full(f_full), .fifo_almost_full(f_afull),
        .fifo_read_req(rreq), .fifo_read_data(f_rdata), .fifo_read_valid(f_rv),
        .fifo_empty(f_empty), .fifo_almost_empty(f_aempty), .fifo_count(f_cnt),
        .fifo_overflow(f_ovf), .fifo_underflow(f_unf)
    );

    int checks = 0;
    int errors = 0;

    // Standard-mode model: words in order, read data appears two edges after the pop request edge's predecessor.
    logic [7:0] sq[$];
    bit         m_pop = 1'b0;
    logic [7:0] m_pop_d = 8'h00;
    bit         m_rv = 1'b0;
    logic [7:0] m_rd = 8'h00;
    bit         ms_ovf = 1'b0, ms_unf = 1'b0;

    // FWFT model: a word is at the head two edges after its write, or right after its predecessor is consumed.
    logic [7:0] fdat[$];
    int         ftim[$];
    int         e = 0;
    int         lc = -100;
    bit         mf_ovf = 1'b0, mf_unf = 1'b0;

    function automatic bit fwft_vis();
        int t;
        if (fdat.size() == 0) return 1'b0;
        t = ftim[0] + 2;
        if (lc > t) t = lc;
        return (t <= e);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        sq.delete();
        fdat.delete();
        ftim.delete();
        lc      = -100;
        m_pop   = 1'b0;
        m_pop_d = 8'h00;
        m_rv    = 1'b0;
        m_rd    = 8'h00;
        ms_ovf  = 1'b0;
        ms_unf  = 1'b0;
        mf_ovf  = 1'b0;
        mf_unf  = 1'b0;
    endtask

    task automatic check_all();
        int n;
        int m;
        bit v;
        n = sq.size();
        chk("std_count",        32'(s_cnt),    n);
        chk("std_empty",        32'(s_empty),  32'(n == 0));
        chk("std_full",         32'(s_full),   32'(n == 8));
        chk("std_almost_full",  32'(s_afull),  32'(n >= 6));
        chk("std_almost_empty", 32'(s_aempty), 32'(n <= 2));
        chk("std_read_valid",   32'(s_rv),     32'(m_rv));
        chk("std_read_data",    32'(s_rdata),  32'(m_rd));
        chk("std_overflow",     32'(s_ovf),    32'(ms_ovf));
        chk("std_underflow",    32'(s_unf),    32'(ms_unf));
        m = fdat.size();
        v = fwft_vis();
        chk("fwft_count",        32'(f_cnt),    m);
        chk("fwft_empty",        32'(f_empty),  32'(!v));
        chk("fwft_read_valid",   32'(f_rv),     32'(v));
        chk("fwft_full",         32'(f_full),   32'(m == 8));
        chk("fwft_almost_full",  32'(f_afull),  32'(m >= 6));
        chk("fwft_almost_empty", 32'(f_aempty), 32'(m <= 2));
        chk("fwft_overflow",     32'(f_ovf),    32'(mf_ovf));
        chk("fwft_underflow",    32'(f_unf),    32'(mf_unf));
        if (v) chk("fwft_read_data", 32'(f_rdata), 32'(fdat[0]));
    endtask

    task automatic step(input bit wr, input logic [7:0] d, input bit rd);
        bit s_wacc, s_racc, f_wacc, f_racc;
        @(negedge clk);
        wreq  = wr;
        wdata = d;
        rreq  = rd;
        s_wacc = wr && (sq.size() < 8);
        s_racc = rd && (sq.size() > 0);
        f_wacc = wr && (fdat.size() < 8);
        f_racc = rd && fwft_vis();
        @(posedge clk);
        e++;
        m_rv = m_pop;
        if (m_pop) m_rd = m_pop_d;
        m_pop = s_racc;
        if (s_racc) m_pop_d = sq.pop_front();
        if (s_wacc) sq.push_back(d);
        ms_ovf = wr && !s_wacc;
        ms_unf = rd && !s_racc;
        if (f_racc) begin
            void'(fdat.pop_front());
            void'(ftim.pop_front());
            lc = e;
        end
        if (f_wacc) begin
            fdat.push_back(d);
            ftim.push_back(e);
        end
        mf_ovf = wr && !f_wacc;
        mf_unf = rd && !f_racc;
        #1;
        check_all();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        wreq = 1'b0;
        rreq = 1'b0;
        rst  = 1'b1;
        #1;
        clear_model();
        check_all();
        @(posedge clk);
        e++;
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        clear_model();
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, then one rejected write.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
        step(1'b1, 8'h99, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Drain in order, then one rejected read.
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Steady push+pop across two pointer wraps.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // Single word into an empty FIFO, then consume it.
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Five words then continuous reads.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);

        // Reset with data queued; the next push is the next word read.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        mid_reset();
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Random traffic, biased toward filling, balanced, then draining.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(99) < (75 - 25 * p), 8'($urandom), $urandom_range(99) < (25 + 25 * p));
            end
        end
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
